afifo_rd_prefetch: RTL and testbench

Read-side prefetch adapter sitting directly downstream of the async FIFO's read port, in the read clock domain. Converts the FIFO's pop / one-cycle-later vld+data protocol into a standard valid/ready stream with a small local buffer, so consumers can apply backpressure without tracking RAM read latency. Issues pops autonomously while credit remains, sustaining one word per cycle.

---
 rtl/afifo_pkg.sv | 12 +
 rtl/afifo_rd_prefetch.sv | 103 ++++++++++
 tb/tb_afifo_rd_prefetch.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_pkg.sv
// rtl/afifo_pkg.sv - shared constants and counter-width helper for the async FIFO read side
`timescale 1ns/1ps
package afifo_pkg;

   localparam int AFIFO_DW = 24;

   // Occupancy counters must represent the value DEPTH itself, hence the extra bit.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/afifo_rd_prefetch.sv
// rtl/afifo_rd_prefetch.sv - turns the FIFO pop/next-cycle-vld read port into a valid/ready stream
// A small register-file buffer is popped autonomously while credit remains.
`timescale 1ns/1ps
module afifo_rd_prefetch
   import afifo_pkg::*;
#(
   parameter int DW    = AFIFO_DW,
   parameter int DEPTH = 4,
   parameter int CW    = cnt_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fifo_empty,
   output logic          fifo_pop,
   input  logic          fifo_vld,
   input  logic [DW-1:0] fifo_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [CW-1:0] level,
   output logic          err
);

   localparam int            AW         = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [CW:0]   CREDIT_LIM = (CW + 1)'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          inflight_q, inflight_d;
   logic          err_q, err_d;

   logic [CW:0]   occ;
   logic          out_fire;
   logic          full;
   logic          spurious;
   logic          overflow;
   logic          wr_en;

   // Credit counts words already stored plus the one whose read data is still on its way.
   always_comb begin
      occ       = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
      fifo_pop  = !fifo_empty && !rst && (occ < CREDIT_LIM);
      out_valid = (cnt_q != '0);
      out_data  = mem_q[rp_q];
      level     = cnt_q;
      err       = err_q;
   end

   always_comb begin
      out_fire = out_valid && out_ready;
      full     = (cnt_q == FULL_CNT);
      spurious = fifo_vld && !inflight_q;
      overflow = fifo_vld && full && !out_fire;
      wr_en    = fifo_vld && !spurious && !overflow;

      mem_d      = mem_q;
      wp_d       = wp_q;
      rp_d       = rp_q;
      cnt_d      = cnt_q;
      inflight_d = fifo_pop;
      err_d      = err_q || spurious || overflow;

      if (wr_en) begin
         mem_d[wp_q] = fifo_data;
         wp_d        = wp_q + AW'(1);
      end
      if (out_fire) begin
         rp_d = rp_q + AW'(1);
      end

      // A dropped word leaves cnt alone; a simultaneous write and read cancel out.
      case ({wr_en, out_fire})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wp_q       <= '0;
         rp_q       <= '0;
         cnt_q      <= '0;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         cnt_q      <= cnt_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_afifo_rd_prefetch.sv
// tb/tb_afifo_rd_prefetch.sv - directed-vector bench for afifo_rd_prefetch with a behavioural FIFO read port
`timescale 1ns/1ps
module tb_afifo_rd_prefetch;

   localparam int DW    = 24;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          fifo_empty = 1'b1;
   logic          fifo_pop;
   logic          fifo_vld = 1'b0;
   logic [DW-1:0] fifo_data = '0;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] level;
   logic          err;

   afifo_rd_prefetch #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_pop   (fifo_pop),
      .fifo_vld   (fifo_vld),
      .fifo_data  (fifo_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .level      (level),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Source FIFO: words are 1,2,3,... ; avail_limit is the total ever written into it.
   int   avail_limit;
   int   sent = 0;
   logic pop_seen = 1'b0;
   logic inject_vld;

   always @(negedge clk) pop_seen = fifo_pop;

   always @(posedge clk) begin
      #1;
      if (inject_vld) begin
         fifo_vld  = 1'b1;
         fifo_data = 24'hABCDEF;
      end else if (pop_seen && !rst) begin
         sent      = sent + 1;
         fifo_vld  = 1'b1;
         fifo_data = DW'(sent);
      end else begin
         fifo_vld  = 1'b0;
      end
      fifo_empty = (sent >= avail_limit);
   end

   typedef struct {
      logic          rdy;
      logic          pop;
      logic          valid;
      logic [DW-1:0] data;
      logic [CW-1:0] level;
   } vec_t;

   vec_t vecs [19];
   int   n_vec = 0;
   int   n_bad = 0;
   int   exp_word;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         @(posedge clk);
         #2;
         out_ready = vecs[i].rdy;
         @(negedge clk);
         chk($sformatf("row%0d.fifo_pop", i), 32'(fifo_pop), 32'(vecs[i].pop));
         chk($sformatf("row%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].valid));
         chk($sformatf("row%0d.level", i), 32'(level), 32'(vecs[i].level));
         chk($sformatf("row%0d.err", i), 32'(err), 32'd0);
         if (vecs[i].valid) begin
            chk($sformatf("row%0d.out_data", i), 32'(out_data), 32'(vecs[i].data));
         end
      end
   endtask

   // Streams n further words through, checking order, stall stability and the credit bound.
   task automatic run_stream(input int n, input bit rnd, input int budget);
      int            got = 0;
      int            cyc = 0;
      bit            started = 1'b0;
      bit            stall = 1'b0;
      logic          last_pop = 1'b0;
      logic [DW-1:0] hold = '0;
      @(posedge clk);
      #2;
      avail_limit = avail_limit + n;
      while (got < n && cyc < budget) begin
         @(posedge clk);
         #2;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         cyc++;
         if (stall) begin
            chk("stall.out_valid", 32'(out_valid), 32'd1);
            chk("stall.out_data", 32'(out_data), 32'(hold));
         end
         chk("credit.bound", 32'(int'(level) + int'(last_pop) <= DEPTH), 32'd1);
         chk("credit.pop", 32'(fifo_pop),
             32'(!fifo_empty && (int'(level) + int'(last_pop) < DEPTH)));
         if (!rnd && started) begin
            chk("stream.out_valid", 32'(out_valid), 32'd1);
         end
         if (out_valid) started = 1'b1;
         if (out_valid && out_ready) begin
            chk("stream.order", 32'(out_data), 32'(DW'(exp_word)));
            exp_word++;
            got++;
         end
         stall    = out_valid && !out_ready;
         hold     = out_data;
         last_pop = fifo_pop;
      end
      chk("stream.words_received", 32'(got), 32'(n));
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 24'd0, 3'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 24'd0, 3'd0};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 24'd1, 3'd1};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 24'd1, 3'd2};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 24'd1, 3'd3};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 24'd1, 3'd4};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 24'd1, 3'd4};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 24'd1, 3'd4};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 24'd2, 3'd3};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 24'd3, 3'd2};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 24'd4, 3'd2};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 24'd5, 3'd2};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 24'd6, 3'd1};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 24'd0, 3'd0};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 24'd0, 3'd0};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 24'd0, 3'd0};
      vecs[16] = '{1'b1, 1'b0, 1'b1, 24'd7, 3'd1};
      vecs[17] = '{1'b1, 1'b0, 1'b0, 24'd0, 3'd0};
      vecs[18] = '{1'b1, 1'b0, 1'b0, 24'd0, 3'd0};

      rst         = 1'b1;
      out_ready   = 1'b0;
      inject_vld  = 1'b0;
      avail_limit = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.fifo_pop", 32'(fifo_pop), 32'd0);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.out_data", 32'(out_data), 32'd0);
      chk("reset.level", 32'(level), 32'd0);
      chk("reset.err", 32'(err), 32'd0);
      rst = 1'b0;

      // Fill with out_ready low, then drain words 1..6.
      @(posedge clk);
      #2;
      avail_limit = 6;
      apply_rows(0, 13);

      // Single word: one pop, out_valid for exactly one cycle.
      @(posedge clk);
      #2;
      avail_limit = 7;
      apply_rows(14, 18);

      // Read data with no pop outstanding.
      @(posedge clk);
      #2;
      inject_vld = 1'b1;
      @(posedge clk);
      #2;
      inject_vld = 1'b0;
      @(negedge clk);
      chk("spurious.err_before", 32'(err), 32'd0);
      @(negedge clk);
      chk("spurious.err", 32'(err), 32'd1);
      chk("spurious.level", 32'(level), 32'd0);
      chk("spurious.out_valid", 32'(out_valid), 32'd0);
      repeat (5) @(negedge clk);
      chk("spurious.err_sticky", 32'(err), 32'd1);

      // Asynchronous reset with three words buffered.
      @(posedge clk);
      #2;
      out_ready   = 1'b0;
      avail_limit = 10;
      for (int c = 0; c < 12 && level != 3'd3; c++) @(negedge clk);
      chk("midreset.level_before", 32'(level), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      chk("midreset.fifo_pop", 32'(fifo_pop), 32'd0);
      chk("midreset.out_valid", 32'(out_valid), 32'd0);
      chk("midreset.out_data", 32'(out_data), 32'd0);
      chk("midreset.level", 32'(level), 32'd0);
      chk("midreset.err", 32'(err), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_word = 11;
      run_stream(2, 1'b0, 8);
      chk("midreset.err_after", 32'(err), 32'd0);

      // Back-to-back streaming, then random backpressure.
      run_stream(100, 1'b0, 106);
      run_stream(1000, 1'b1, 6000);
      chk("final.err", 32'(err), 32'd0);
      chk("final.all_popped", 32'(sent), 32'(avail_limit));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
